// File: rtl/shift_add_mul16.sv
// shift_add_mul16: sequential 16x16 unsigned shift-add multiplier.
//
// Operands are accepted over a valid/ready handshake. The multiplier then runs 16
// shift-add steps through a single combinational adder. The 32-bit product is
// presented over a valid/ready handshake.
//
// Ports:
//   clk_i        clock; all state updates on the rising edge
//   rst_i        synchronous, active-high reset
//   in_valid_i   operand pair valid
//   in_ready_o   block can accept operands (IDLE and not in reset)
//   a_i          multiplicand
//   b_i          multiplier
//   out_valid_o  product valid (DONE state)
//   out_ready_i  consumer accepts product
//   product_o    unsigned a*b, meaningful while out_valid_o is high
//   busy_o       high in RUN or DONE
//
// The file also holds the 16-bit combinational adder the multiplier consumes
// (a, b -> sum, carry; carry-in fixed 0), so the block is self-contained.

module adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

module shift_add_mul16 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] product_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;     // multiplicand
    logic [WIDTH-1:0] acc_q, acc_d; // upper product half (A)
    logic [WIDTH-1:0] q_q, q_d;     // multiplier, shifted into lower product half (Q)
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;

    // Add M only when the current multiplier LSB is set.
    assign add_b = q_q[0] ? m_q : '0;

    adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i     (acc_q),
        .b_i     (add_b),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    m_d     = a_i;
                    q_d     = b_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // The carry becomes the new MSB of A; the sum LSB shifts into Q.
                acc_d = {add_carry, add_sum[WIDTH-1:1]};
                q_d   = {add_sum[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    // The reset term keeps in_ready low while rst_i is high, even in IDLE.
    assign in_ready_o  = (state_q == StIdle) && !rst_i;
    assign busy_o      = (state_q != StIdle);
    assign out_valid_o = (state_q == StDone);
    assign product_o   = {acc_q, q_q};

endmodule
